// File: rtl/match_event_logger_if.sv
// match_event_logger_if: comparator stream, event FIFO read side and status bundle for the match event logger
// Optional MATCH_LOG_DATA_EN adds the evt_data head word.
interface match_event_logger_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    logic                     data_valid;
    logic                     sop;
    logic                     eop;
    logic                     match;
    logic [31:0]              data_in;
    logic                     comparator_clear;
    logic                     evt_rd;
    logic                     evt_valid;
    logic [15:0]              evt_pkt;
    logic [10:0]              evt_word;
    logic [$clog2(DEPTH):0]   evt_count;
    logic [CNT_W-1:0]         match_total;
    logic                     overflow;
    logic                     proto_err;
    logic                     status_clr;
`ifdef MATCH_LOG_DATA_EN
    logic [31:0]              evt_data;
`endif

    modport master (
        output data_valid, sop, eop, match, data_in, evt_rd, status_clr,
        input  comparator_clear, evt_valid, evt_pkt, evt_word, evt_count,
               match_total, overflow, proto_err
`ifdef MATCH_LOG_DATA_EN
        , input evt_data
`endif
    );

    modport slave (
        input  data_valid, sop, eop, match, data_in, evt_rd, status_clr,
        output comparator_clear, evt_valid, evt_pkt, evt_word, evt_count,
               match_total, overflow, proto_err
`ifdef MATCH_LOG_DATA_EN
        , output evt_data
`endif
    );
endinterface

// File: rtl/match_event_logger.sv
// match_event_logger: logs rising match events as {pkt, word} records into a FWFT FIFO and clears the comparator after each packet
// Optional MATCH_LOG_DATA_EN also stores the detection-cycle data word per record (evt_data).
module match_event_logger #(
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input logic                 clk,
    input logic                 n_rst,
    match_event_logger_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
`ifdef MATCH_LOG_DATA_EN
    localparam int RW = 59;
`else
    localparam int RW = 27;
`endif

    typedef enum logic [1:0] {IDLE, IN_PKT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            clear_q, clear_d;
    logic [15:0]     pkt_q, pkt_d;
    logic [10:0]     word_q, word_d;
    logic            match_prev_q, match_prev_d;
    logic            push_q, push_d;
    logic [RW-1:0]   rec_q, rec_d;
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic            ovf_q, ovf_d;
    logic            perr_q, perr_d;
    logic [RW-1:0]   mem_q [DEPTH];

    logic            acc_sop, perr_set, empty, full, pop, wr_en;
    logic [AW:0]     count;
    logic [RW-1:0]   head;

    assign acc_sop  = bus.data_valid & bus.sop & (state_q != FLUSH);
    assign perr_set = bus.data_valid & ((bus.sop & (state_q != IDLE)) | (~bus.sop & (state_q == IDLE)));
    assign count    = wr_q - rd_q;
    assign empty    = (wr_q == rd_q);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = bus.evt_rd & ~empty;
    assign wr_en    = push_q & (~full | pop);
    assign head     = mem_q[rd_q[AW-1:0]];

    // state register and all datapath flops
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            flush_cnt_q  <= '0;
            clear_q      <= 1'b0;
            pkt_q        <= '0;
            word_q       <= '0;
            match_prev_q <= 1'b0;
            push_q       <= 1'b0;
            rec_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            total_q      <= '0;
            ovf_q        <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            clear_q      <= clear_d;
            pkt_q        <= pkt_d;
            word_q       <= word_d;
            match_prev_q <= match_prev_d;
            push_q       <= push_d;
            rec_q        <= rec_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            total_q      <= total_d;
            ovf_q        <= ovf_d;
            perr_q       <= perr_d;
        end
    end

    // event storage; contents are only visible through the valid-gated head
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= rec_q;
    end

    // framing FSM next state; flush counter runs 1..FLUSH_CYCLES while in FLUSH
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_sop) state_d = bus.eop ? FLUSH : IN_PKT;
            IN_PKT:  if (bus.data_valid & bus.eop) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == FW'(FLUSH_CYCLES)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        flush_cnt_d = (state_d != FLUSH) ? '0 : (state_q == FLUSH) ? flush_cnt_q + FW'(1) : FW'(1);
    end

    // FSM output: clear pulse lands in the last FLUSH cycle, FLUSH_CYCLES after the eop cycle
    always_comb begin
        clear_d = (state_d == FLUSH) && (flush_cnt_d == FW'(FLUSH_CYCLES));
    end

    // packet/word tracking, event capture, FIFO pointers and status
    always_comb begin
        pkt_d        = acc_sop ? pkt_q + 16'd1 : pkt_q;
        word_d       = acc_sop ? 11'd0 :
                       (bus.data_valid && state_q == IN_PKT && word_q != 11'h7ff) ? word_q + 11'd1 : word_q;
        match_prev_d = clear_q ? 1'b0 : bus.match;
        push_d       = (state_q == IN_PKT || state_q == FLUSH) & bus.match & ~match_prev_q;
`ifdef MATCH_LOG_DATA_EN
        rec_d        = {pkt_d, word_d, bus.data_in};
`else
        rec_d        = {pkt_d, word_d};
`endif
        wr_d         = wr_q + (AW+1)'(wr_en);
        rd_d         = rd_q + (AW+1)'(pop);
        total_d      = bus.status_clr ? CNT_W'(push_q) :
                       (push_q && !(&total_q)) ? total_q + CNT_W'(1) : total_q;
        ovf_d        = (push_q & full & ~pop) | (ovf_q & ~bus.status_clr);
        perr_d       = perr_set | (perr_q & ~bus.status_clr);
    end

    assign bus.comparator_clear = clear_q;
    assign bus.evt_valid        = ~empty;
    assign bus.evt_pkt          = empty ? 16'd0 : head[RW-1 -: 16];
    assign bus.evt_word         = empty ? 11'd0 : head[RW-17 -: 11];
    assign bus.evt_count        = count;
    assign bus.match_total      = total_q;
    assign bus.overflow         = ovf_q;
    assign bus.proto_err        = perr_q;
`ifdef MATCH_LOG_DATA_EN
    assign bus.evt_data         = empty ? 32'd0 : head[31:0];
`else
    logic unused_data;
    assign unused_data = ^bus.data_in;
`endif
endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Sits directly downstream of the MAC address comparator. Consumes the comparator's delayed 32-bit word stream, framing strobes and sticky match flag.
- Logs each new match as an event record {packet number, word offset} into a small FIFO. The Atom-side register interface drains the FIFO.
- Owns per-packet housekeeping: after each end-of-packet it drives the comparator's clear input once the comparator pipeline has drained.
- Also keeps a saturating total-match counter and sticky overflow/protocol-error status.

Parameters:
DEPTH, 8, event FIFO entries (power of two, >=2)
CNT_W, 16, width of total-match counter
FLUSH_CYCLES, 4, cycles waited after eop before pulsing comparator clear (>=1)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
data_valid  in  1  word on data_in valid this cycle
sop  in  1  first word of packet (qualified by data_valid)
eop  in  1  last word of packet (qualified by data_valid)
match  in  1  sticky match from comparator
data_in  in  32  comparator data_out word
comparator_clear  out  1  one-cycle clear pulse to comparator
evt_rd  in  1  pop head event
evt_valid  out  1  FIFO non-empty
evt_pkt  out  16  head event packet number
evt_word  out  11  head event word offset
evt_count  out  clog2(DEPTH)+1  FIFO occupancy
match_total  out  CNT_W  saturating count of logged-or-dropped match events
overflow  out  1  sticky: event dropped due to full FIFO
proto_err  out  1  sticky: framing violation
status_clr  in  1  clears overflow, proto_err, match_total

Behaviour:
- Reset is synchronous, active-low, at posedge clk. All outputs are 0 after reset: FIFO empty, pkt_num=0, word_cnt=0, state IDLE, match_d=0.
- FSM states:
  - IDLE: valid&sop -> IN_PKT. valid&sop&eop -> FLUSH.
  - IN_PKT: valid&eop -> FLUSH.
  - FLUSH: counts FLUSH_CYCLES cycles, then pulses comparator_clear for 1 cycle and goes to IDLE.
- comparator_clear is registered, high exactly 1 cycle per packet, never in IDLE/IN_PKT otherwise.
- Packet number: increments (wraps 16 bits) on every accepted sop. First packet after reset is numbered 1.
- Word offset: set to 0 on the sop word, +1 per subsequent valid word, saturates at 2047.
- Violations (all set proto_err):
  - sop in IN_PKT: new packet begins (pkt_num++, word_cnt=0), state stays IN_PKT.
  - sop in FLUSH: word ignored, flush continues.
  - valid word without sop in IDLE: ignored.
- Match event: match & ~match_d while state is IN_PKT or FLUSH. match_d is match registered every cycle and is cleared together with the comparator clear.
- Event record = {current pkt_num, current word_cnt}. Push occurs the cycle after detection (1-cycle latency).
- match_total increments on every event, saturates at 2^CNT_W-1.
- FIFO is first-word fall-through: evt_pkt/evt_word show the head whenever evt_valid=1. Head outputs are 0 when empty.
- evt_rd while empty is ignored.
- Push while full: the event is dropped and overflow is set, unless a pop occurs the same cycle. Push+pop when full both succeed and occupancy is unchanged. Push+pop when empty: push only.
- status_clr clears the sticky bits and match_total. A same-cycle set event wins over clear.
- Reset mid-packet: everything returns to reset values; no comparator_clear pulse is issued.

Optional Feature:
- Macro: MATCH_LOG_DATA_EN.
- When defined:
  - Each event record also stores data_in from the detection cycle.
  - Extra output port evt_data out 32 shows the head record's data word; it is 0 when empty.
- When undefined: the port and storage are absent. All other behaviour is identical.

Test Plan:
- Reset, then a 16-word packet with match rising on the 6th valid word (offset 5) -> one event pkt=1 word=5, evt_count=1, match_total=1. comparator_clear pulses exactly 4 cycles after the eop cycle.
- DEPTH+1 matches across 9 single-match packets, no reads -> evt_count=8, overflow=1, match_total=9. The head remains pkt=1.
- Full FIFO, evt_rd asserted in the same cycle as a new event -> evt_count stays 8, overflow stays 0, new tail is the new event.
- sop mid-packet at word 3 -> proto_err=1, pkt_num increments, next word offset=1. Then status_clr -> proto_err=0, match_total=0.
- Packet of 3000 words -> word offset saturates at 2047. A match at the end is logged with word=2047.
- With MATCH_LOG_DATA_EN: match detected while data_in=32'hDEADBEEF -> evt_data=32'hDEADBEEF at head.
